nand_target_emu: RTL and testbench

- Synthesizable NAND flash responder that sits on the far end of the NAND bus from the existing NAND master.
- Lets the UART/NAND-master path be brought up and regression-tested on the board, or in simulation, without a real flash chip.
- Oversamples the master's strobes with hw_clk and latches commands, addresses and data on the nWE rising edge.
- Returns data, status and ID bytes on nRE, and drives R/nB through busy periods.
- Backing store is a small on-chip page array plus one page register.

---
 rtl/nand_target_emu.sv | 269 ++++++++++++++++++++++++++
 tb/tb_nand_target_emu.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/nand_target_emu.sv
// NAND flash target emulator: answers the NAND master from a small on-chip page array.
// Optional macro NAND_EMU_WP_EN enables write-protect handling and the fail flag.
module nand_target_emu #(
  parameter int         PAGE_BYTES = 64,
  parameter int         NUM_PAGES  = 4,
  parameter int         TBUSY_READ = 80,
  parameter int         TBUSY_PROG = 200,
  parameter logic [7:0] ID0        = 8'hEC,
  parameter logic [7:0] ID1        = 8'hF1,
  parameter logic [7:0] ID2        = 8'h00,
  parameter logic [7:0] ID3        = 8'h95
) (
  input  logic       hw_clk,
  input  logic       reset,
  input  logic       nand_cle,
  input  logic       nand_ale,
  input  logic       nand_nwe,
  input  logic       nand_nre,
  input  logic       nand_nce,
  input  logic       nand_nwp,
  output logic       nand_rnb,
  input  logic [7:0] nand_din,
  output logic [7:0] nand_dout,
  output logic       nand_doe,
  output logic [7:0] last_cmd
);

  // Only the low address byte carries column/row bits, so pages and page count are limited to 256.
  localparam int CW = $clog2(PAGE_BYTES);
  localparam int RW = $clog2(NUM_PAGES);
  localparam int AW = CW + RW;
  localparam int ARRAY_BYTES = PAGE_BYTES * NUM_PAGES;
  localparam logic [15:0] INIT_LAST = 16'(ARRAY_BYTES - 1);
  localparam logic [15:0] PB16      = 16'(PAGE_BYTES);
  localparam logic [15:0] T_READ    = 16'(TBUSY_READ);
  localparam logic [15:0] T_PROG    = 16'(TBUSY_PROG);
  localparam logic [15:0] T_RESET   = 16'd8;
  // Idle levels of {nwp, ale, cle, nce, nre, nwe}
  localparam logic [5:0] SYNC_IDLE = 6'b100111;

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_ADDR, S_BUSY, S_READ_OUT, S_ID_OUT, S_STATUS} state_t;
  typedef enum logic [2:0] {OP_NONE, OP_RESET, OP_READ, OP_PROG, OP_ERASE, OP_ID} op_t;

  function automatic logic [7:0] status_byte(input logic wp_bit, input logic rdy, input logic fail);
    return {wp_bit, rdy, 5'b00000, fail};
  endfunction

  logic [5:0]    sync_p0, sync_p1;
  logic          nwe_p2, nre_p2;
  logic [7:0]    din_p0, din_p1;
  state_t        state_q, state_d;
  op_t           op_q, op_d;
  logic [15:0]   busy_len_q, busy_len_d, cnt_q;
  logic          start_busy;
  logic [2:0]    addr_idx_q, apos;
  logic [CW-1:0] ptr_q;
  logic [1:0]    id_ptr_q;
  logic [RW-1:0] row_q;
  logic          doe_q, fail_q;
  logic [7:0]    dout_q, last_cmd_q, cur_byte;
  logic [7:0]    mem  [ARRAY_BYTES];
  logic [7:0]    preg [PAGE_BYTES];
  logic          mem_we, preg_we;
  logic [AW-1:0] mem_waddr;
  logic [CW-1:0] preg_waddr;
  logic [7:0]    mem_wdata, preg_wdata;

  // Stage p0/p1: two-flop synchronizers; p2: previous synced strobe level for edge detection
  always_ff @(posedge hw_clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= SYNC_IDLE;
      sync_p1 <= SYNC_IDLE;
      nwe_p2  <= 1'b1;
      nre_p2  <= 1'b1;
    end else begin
      sync_p0 <= {nand_nwp, nand_ale, nand_cle, nand_nce, nand_nre, nand_nwe};
      sync_p1 <= sync_p0;
      nwe_p2  <= sync_p1[0];
      nre_p2  <= sync_p1[1];
    end
  end

  always_ff @(posedge hw_clk) begin
    din_p0 <= nand_din;
    din_p1 <= din_p0;
  end

  logic nwe_s, nre_s, nce_s, cle_s, ale_s, nwp_s;
  assign nwe_s = sync_p1[0];
  assign nre_s = sync_p1[1];
  assign nce_s = sync_p1[2];
  assign cle_s = sync_p1[3];
  assign ale_s = sync_p1[4];
  assign nwp_s = sync_p1[5];

  logic wp_block, wp_bit;
`ifdef NAND_EMU_WP_EN
  assign wp_block = ~nwp_s;
  assign wp_bit   = nwp_s;
`else
  logic unused_nwp;
  assign wp_block   = 1'b0;
  assign wp_bit     = 1'b1;
  assign unused_nwp = nwp_s;
`endif

  logic nwe_rise, nre_fall, nre_rise, wr_ev, rnb, out_mode;
  logic cmd_ev, addr_ev, data_ev, rd_fall, rd_rise;
  assign nwe_rise = nwe_s & ~nwe_p2;
  assign nre_fall = ~nre_s & nre_p2;
  assign nre_rise = nre_s & ~nre_p2;
  assign wr_ev    = nwe_rise & ~nce_s;
  assign rnb      = (state_q != S_INIT) && (state_q != S_BUSY);
  assign out_mode = (state_q == S_READ_OUT) || (state_q == S_ID_OUT) || (state_q == S_STATUS);
  // While busy only the reset command gets through; INIT is never interrupted.
  assign cmd_ev   = wr_ev & cle_s & ~ale_s & (state_q != S_INIT) & (rnb | (din_p1 == 8'hFF));
  assign addr_ev  = wr_ev & ale_s & ~cle_s & (state_q == S_ADDR);
  assign data_ev  = wr_ev & ~cle_s & ~ale_s & (state_q == S_ADDR) & (op_q == OP_PROG);
  assign rd_fall  = nre_fall & ~nce_s & ~nwe_rise & out_mode;
  assign rd_rise  = nre_rise & doe_q;
  // Erase takes row bytes first, so shift its byte position onto the row slots.
  assign apos     = (op_q == OP_ERASE) ? addr_idx_q + 3'd2 : addr_idx_q;

  always_ff @(posedge hw_clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_INIT;
      op_q       <= OP_NONE;
      busy_len_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      busy_len_q <= busy_len_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    busy_len_d = busy_len_q;
    start_busy = 1'b0;
    case (state_q)
      S_INIT: if (cnt_q == INIT_LAST) state_d = S_IDLE;
      S_BUSY: if (cnt_q == busy_len_q - 16'd1) state_d = (op_q == OP_READ) ? S_READ_OUT : S_IDLE;
      S_ADDR: if (addr_ev && op_q == OP_ID) state_d = (din_p1 == 8'h00) ? S_ID_OUT : S_IDLE;
      default: ;
    endcase
    if (cmd_ev) begin
      state_d = S_IDLE;
      op_d    = OP_NONE;
      case (din_p1)
        8'hFF: begin state_d = S_BUSY; op_d = OP_RESET; busy_len_d = T_RESET; start_busy = 1'b1; end
        8'h90: begin state_d = S_ADDR; op_d = OP_ID; end
        8'h00: begin state_d = S_ADDR; op_d = OP_READ; end
        8'h80: begin state_d = S_ADDR; op_d = OP_PROG; end
        8'h60: begin state_d = S_ADDR; op_d = OP_ERASE; end
        8'h70: state_d = S_STATUS;
        8'h30: if (state_q == S_ADDR && op_q == OP_READ) begin
          state_d = S_BUSY; op_d = OP_READ; busy_len_d = T_READ; start_busy = 1'b1;
        end
        8'h10: if (state_q == S_ADDR && op_q == OP_PROG) begin
          state_d = S_BUSY; op_d = OP_PROG; busy_len_d = T_PROG; start_busy = 1'b1;
        end
        8'hD0: if (state_q == S_ADDR && op_q == OP_ERASE) begin
          state_d = S_BUSY; op_d = OP_ERASE; busy_len_d = T_PROG; start_busy = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge hw_clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      addr_idx_q <= '0;
      ptr_q      <= '0;
      id_ptr_q   <= '0;
      doe_q      <= 1'b0;
      dout_q     <= 8'h00;
      last_cmd_q <= 8'h00;
      fail_q     <= 1'b0;
    end else begin
      if (start_busy) cnt_q <= '0;
      else if (state_q == S_INIT || state_q == S_BUSY) cnt_q <= cnt_q + 16'd1;

      if (cmd_ev) last_cmd_q <= din_p1;
      if (start_busy && (op_d == OP_PROG || op_d == OP_ERASE)) fail_q <= wp_block;

      if (cmd_ev && state_d == S_ADDR) begin
        addr_idx_q <= '0;
        ptr_q      <= '0;
      end else if (addr_ev) begin
        if (addr_idx_q != 3'd4) addr_idx_q <= addr_idx_q + 3'd1;
        if (apos == 3'd0) ptr_q <= din_p1[CW-1:0];
        if (op_q == OP_ID) id_ptr_q <= 2'd0;
      end else if (data_ev || (rd_rise && state_q == S_READ_OUT)) begin
        ptr_q <= ptr_q + CW'(1);
      end
      if (rd_rise && state_q == S_ID_OUT) id_ptr_q <= id_ptr_q + 2'd1;

      if (cmd_ev) doe_q <= 1'b0;
      else if (rd_fall) begin
        doe_q  <= 1'b1;
        dout_q <= cur_byte;
      end else if (rd_rise) doe_q <= 1'b0;
    end
  end

  always_ff @(posedge hw_clk) begin
    if (cmd_ev && state_d == S_ADDR) row_q <= '0;
    else if (addr_ev && apos == 3'd2) row_q <= din_p1[RW-1:0];
  end

  always_comb begin
    cur_byte = 8'h00;
    case (state_q)
      S_READ_OUT: cur_byte = preg[ptr_q];
      S_STATUS:   cur_byte = status_byte(wp_bit, rnb, fail_q);
      S_ID_OUT:
        case (id_ptr_q)
          2'd0:    cur_byte = ID0;
          2'd1:    cur_byte = ID1;
          2'd2:    cur_byte = ID2;
          default: cur_byte = ID3;
        endcase
      default: ;
    endcase
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = {row_q, cnt_q[CW-1:0]};
    mem_wdata = 8'hFF;
    if (state_q == S_INIT) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q[AW-1:0];
    end else if (state_q == S_BUSY && cnt_q < PB16 && !fail_q) begin
      if (op_q == OP_PROG) begin
        mem_we    = 1'b1;
        mem_wdata = preg[cnt_q[CW-1:0]];
      end else if (op_q == OP_ERASE) begin
        mem_we    = 1'b1;
      end
    end
  end

  always_comb begin
    preg_we    = 1'b0;
    preg_waddr = ptr_q;
    preg_wdata = din_p1;
    if (data_ev) begin
      preg_we = 1'b1;
    end else if (state_q == S_BUSY && op_q == OP_READ && cnt_q < PB16) begin
      preg_we    = 1'b1;
      preg_waddr = cnt_q[CW-1:0];
      preg_wdata = mem[{row_q, cnt_q[CW-1:0]}];
    end
  end

  always_ff @(posedge hw_clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (preg_we) preg[preg_waddr] <= preg_wdata;
  end

  assign nand_rnb  = rnb;
  assign nand_dout = dout_q;
  assign nand_doe  = doe_q & ~nce_s;
  assign last_cmd  = last_cmd_q;

endmodule

// File: tb/tb_nand_target_emu.sv
// Directed bench for nand_target_emu: reset/INIT, Read ID, program/erase/read, status, reset abort.
module tb_nand_target_emu;
  logic       hw_clk = 1'b0;
  logic       reset = 1'b1;
  logic       cle = 1'b0, ale = 1'b0, nwe = 1'b1, nre = 1'b1, nce = 1'b0, nwp = 1'b1;
  logic [7:0] din = 8'h00;
  logic       rnb, doe;
  logic [7:0] dout, last_cmd;
  int         errors = 0;
  int         checks = 0;
  int         n;

`ifdef NAND_EMU_WP_EN
  localparam logic [7:0] EXP_STAT_WP = 8'h41;
  localparam logic [7:0] EXP_D0      = 8'hFF;
`else
  localparam logic [7:0] EXP_STAT_WP = 8'hC0;
  localparam logic [7:0] EXP_D0      = 8'h11;
`endif

  nand_target_emu dut (
    .hw_clk(hw_clk), .reset(reset),
    .nand_cle(cle), .nand_ale(ale), .nand_nwe(nwe), .nand_nre(nre),
    .nand_nce(nce), .nand_nwp(nwp), .nand_rnb(rnb),
    .nand_din(din), .nand_dout(dout), .nand_doe(doe), .last_cmd(last_cmd)
  );

  always #5 hw_clk = ~hw_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int c);
    repeat (c) @(posedge hw_clk);
    #1;
  endtask

  task automatic wr(input logic cl, input logic al, input logic [7:0] d);
    cle = cl; ale = al; din = d; nwe = 1'b0;
    tick(4);
    nwe = 1'b1;
    tick(4);
    cle = 1'b0; ale = 1'b0;
  endtask

  task automatic cmd(input logic [7:0] c);  wr(1'b1, 1'b0, c); endtask
  task automatic addr(input logic [7:0] a); wr(1'b0, 1'b1, a); endtask
  task automatic data(input logic [7:0] d); wr(1'b0, 1'b0, d); endtask

  // Issue a command and measure how many cycles R/nB stays low afterwards.
  task automatic cmd_busy(input logic [7:0] c, output int cyc);
    cle = 1'b1; ale = 1'b0; din = c; nwe = 1'b0;
    tick(4);
    nwe = 1'b1;
    cyc = 0;
    for (int i = 0; i < 8 && rnb; i++) tick(1);
    if (!rnb) begin
      cyc = 1;
      for (int i = 0; i < 1000; i++) begin
        tick(1);
        if (rnb) break;
        cyc++;
      end
    end
    cle = 1'b0;
    tick(2);
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] exp, input bit chk_oe);
    nre = 1'b0;
    tick(4);
    check(tag, dout, exp);
    if (chk_oe) check({tag, "_oe_on"}, doe, 1'b1);
    nre = 1'b1;
    tick(4);
    if (chk_oe) check({tag, "_oe_off"}, doe, 1'b0);
  endtask

  task automatic read_setup(input logic [7:0] col, input logic [7:0] row);
    int cyc;
    cmd(8'h00); addr(col); addr(8'h00); addr(row); addr(8'h00);
    cmd_busy(8'h30, cyc);
    check("read_busy", cyc, 80);
  endtask

  task automatic init_count(input string tag);
    int cyc;
    cyc = 0;
    for (int i = 0; i < 2000; i++) begin
      tick(1);
      cyc++;
      if (rnb) break;
    end
    check(tag, cyc, 256);
  endtask

  initial begin
    tick(3);
    check("rst_rnb", rnb, 1'b0);
    check("rst_doe", doe, 1'b0);
    check("rst_dout", dout, 8'h00);
    check("rst_last_cmd", last_cmd, 8'h00);
    reset = 1'b0;
    init_count("init_busy");
    read_setup(8'h00, 8'h02);
    rd_chk("p2c0", 8'hFF, 1'b0);

    cmd(8'h90);
    check("last_cmd_90", last_cmd, 8'h90);
    addr(8'h00);
    rd_chk("id0", 8'hEC, 1'b1);
    rd_chk("id1", 8'hF1, 1'b1);
    rd_chk("id2", 8'h00, 1'b1);
    rd_chk("id3", 8'h95, 1'b1);
    rd_chk("id_wrap", 8'hEC, 1'b1);

    cmd(8'h80); addr(8'h05); addr(8'h00); addr(8'h01); addr(8'h00);
    data(8'hA5); data(8'h5A); data(8'h3C);
    cmd_busy(8'h10, n);
    check("prog_busy", n, 200);
    read_setup(8'h04, 8'h01);
    rd_chk("r1c4", 8'hFF, 1'b0);
    rd_chk("r1c5", 8'hA5, 1'b0);
    rd_chk("r1c6", 8'h5A, 1'b0);
    rd_chk("r1c7", 8'h3C, 1'b0);

    cmd(8'h60); addr(8'h01); addr(8'h00);
    cmd_busy(8'hD0, n);
    check("erase_busy", n, 200);
    read_setup(8'h05, 8'h01);
    rd_chk("r1c5_erased", 8'hFF, 1'b0);

    cmd(8'h70);
    nre = 1'b0;
    tick(4);
    check("status", dout, 8'hC0);
    check("status_oe", doe, 1'b1);
    nce = 1'b1;
    tick(3);
    check("nce_masks_oe", doe, 1'b0);
    nce = 1'b0;
    tick(3);
    check("nce_restore_oe", doe, 1'b1);
    nre = 1'b1;
    tick(4);
    check("status_oe_off", doe, 1'b0);

    cmd_busy(8'hFF, n);
    check("reset_cmd_busy", n, 8);
    check("last_cmd_ff", last_cmd, 8'hFF);

    nwp = 1'b0;
    cmd(8'h80); addr(8'h00); addr(8'h00); addr(8'h00); addr(8'h00);
    data(8'h11);
    cmd_busy(8'h10, n);
    check("prog_wp_busy", n, 200);
    cmd(8'h70);
    rd_chk("status_wp", EXP_STAT_WP, 1'b0);
    nwp = 1'b1;
    read_setup(8'h00, 8'h00);
    rd_chk("r0c0", EXP_D0, 1'b0);

    cmd(8'h00);
    cmd_busy(8'h30, n);
    check("noaddr_busy", n, 80);
    rd_chk("noaddr_r0c0", EXP_D0, 1'b0);

    read_setup(8'h7F, 8'h00);
    rd_chk("r0c63", 8'hFF, 1'b0);
    rd_chk("r0_wrap_c0", EXP_D0, 1'b0);

    cmd(8'h55);
    check("last_cmd_unknown", last_cmd, 8'h55);
    nre = 1'b0;
    tick(4);
    check("unknown_idle_oe", doe, 1'b0);
    nre = 1'b1;
    tick(4);

    cmd(8'h80); addr(8'h00); addr(8'h00); addr(8'h02); addr(8'h00);
    data(8'h77);
    cmd(8'h10);
    tick(20);
    check("busy_before_reset", rnb, 1'b0);
    reset = 1'b1;
    #1;
    check("mid_rst_rnb", rnb, 1'b0);
    check("mid_rst_doe", doe, 1'b0);
    check("mid_rst_dout", dout, 8'h00);
    check("mid_rst_last_cmd", last_cmd, 8'h00);
    tick(2);
    reset = 1'b0;
    init_count("reinit_busy");
    read_setup(8'h00, 8'h02);
    rd_chk("p2c0_after_reinit", 8'hFF, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
